// File: rtl/temporizador_bcd_if.sv
// Control and display bus of the BCD countdown timer: user-input pulses in,
// packed-BCD digits and status out.
interface temporizador_bcd_if;
    logic       tick_1hz;
    logic       Prog_on;
    logic [3:0] Cursor;
    logic       inc;
    logic       dec;
    logic       start;
    logic       stop;
    logic [7:0] digit_TimerHORA;
    logic [7:0] digit_TimerMIN;
    logic [7:0] digit_TimerSEG;
    logic       running;
    logic       timer_done;

    modport master (
        output tick_1hz, Prog_on, Cursor, inc, dec, start, stop,
        input  digit_TimerHORA, digit_TimerMIN, digit_TimerSEG, running, timer_done
    );

    modport slave (
        input  tick_1hz, Prog_on, Cursor, inc, dec, start, stop,
        output digit_TimerHORA, digit_TimerMIN, digit_TimerSEG, running, timer_done
    );
endinterface

// File: rtl/temporizador_bcd.sv
// BCD hh:mm:ss countdown timer with per-field programming and a held
// terminal flag at 00:00:00.
//
// state | meaning
// IDLE  | value held, waiting for start
// PROG  | Prog_on high, inc/dec edit the field chosen by Cursor
// RUN   | one-second decrement on every tick_1hz
// DONE  | reached 00:00:00, timer_done held until stop/start
module temporizador_bcd #(
    parameter logic [7:0] HOUR_MAX = 8'h23
) (
    input  logic               clk,
    input  logic               reset,
    temporizador_bcd_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PROG = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_hora, r_min, r_seg;
    logic       r_running, r_done;

    logic [1:0] w_state_nxt;
    logic [7:0] w_hora_nxt, w_min_nxt, w_seg_nxt;
    logic [7:0] w_t_hora, w_t_min, w_t_seg;
    logic       w_edit;
    logic       w_nonzero;

    // Both helpers wrap at the field limits, so they also serve the borrow chain.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        if (v == vmax)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        if (v == 8'h00)
            return vmax;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign w_nonzero = (r_hora != 8'h00) || (r_min != 8'h00) || (r_seg != 8'h00);
    assign w_edit    = bus.inc ^ bus.dec;

    assign w_t_seg  = bcd_dec(r_seg, 8'h59);
    assign w_t_min  = (r_seg == 8'h00) ? bcd_dec(r_min, 8'h59) : r_min;
    assign w_t_hora = (r_seg == 8'h00 && r_min == 8'h00) ? bcd_dec(r_hora, HOUR_MAX) : r_hora;

    always_comb begin
        w_state_nxt = r_state;
        w_hora_nxt  = r_hora;
        w_min_nxt   = r_min;
        w_seg_nxt   = r_seg;
        if (bus.Prog_on) begin
            w_state_nxt = PROG;
            // Edits only once already in PROG; the entry cycle just switches state.
            if (r_state == PROG && w_edit) begin
                case (bus.Cursor)
                    4'd6: w_hora_nxt = bus.inc ? bcd_inc(r_hora, HOUR_MAX) : bcd_dec(r_hora, HOUR_MAX);
                    4'd7: w_min_nxt  = bus.inc ? bcd_inc(r_min, 8'h59) : bcd_dec(r_min, 8'h59);
                    4'd8: w_seg_nxt  = bus.inc ? bcd_inc(r_seg, 8'h59) : bcd_dec(r_seg, 8'h59);
                    default: ;
                endcase
            end
        end else begin
            case (r_state)
                PROG: w_state_nxt = IDLE;
                IDLE: if (bus.start && w_nonzero) w_state_nxt = RUN;
                RUN: begin
                    if (bus.stop) begin
                        w_state_nxt = IDLE;
                    end else if (bus.tick_1hz) begin
                        w_hora_nxt = w_t_hora;
                        w_min_nxt  = w_t_min;
                        w_seg_nxt  = w_t_seg;
                        if ({w_t_hora, w_t_min, w_t_seg} == 24'h000000)
                            w_state_nxt = DONE;
                    end
                end
                DONE: if (bus.stop || bus.start) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_hora    <= 8'h00;
            r_min     <= 8'h00;
            r_seg     <= 8'h00;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hora    <= w_hora_nxt;
            r_min     <= w_min_nxt;
            r_seg     <= w_seg_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= (w_state_nxt == DONE);
        end
    end

    assign bus.digit_TimerHORA = r_hora;
    assign bus.digit_TimerMIN  = r_min;
    assign bus.digit_TimerSEG  = r_seg;
    assign bus.running         = r_running;
    assign bus.timer_done      = r_done;

endmodule
